// File: rtl/tt_um_cyl_rect.sv
// tt_um_cyl_rect
// Cylindrical-to-rectangular converter: x = r*cos(theta), y = r*sin(theta),
// using a 10-step rotation-mode CORDIC with quadrant folding.
//
// Ports
//   clk      tile clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      tile enable; all state holds while low
//   ui_in    [6:0] r (unsigned magnitude), [7] start (rising edge launches)
//   uio_in   [5:0] theta (64 units per turn), [6] sel (0 = x, 1 = y), [7] unused
//   uo_out   selected result, two's complement, saturated to [-127, 127]
//   uio_out  [7] done, [6:0] zero
//   uio_oe   constant 8'h80 (only bit 7 is driven)
//
// State | meaning
// IDLE   | no result computed since reset; waiting for a launch
// ROTATE | iter 0..9: one CORDIC step per enabled edge; iter 10: write-back
// DONE   | results held in xr/yr with done=1; a launch reloads
module tt_um_cyl_rect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WRITE_BACK = 4'd10;

  state_t state, state_nxt;

  logic               start_q;
  logic               launch;
  logic               load;
  logic               step;
  logic               write_back;
  logic [3:0]         iter;
  logic signed [18:0] x, y;
  logic signed [16:0] z;
  logic [1:0]         quad;
  logic [7:0]         xr, yr;
  logic               done;

  logic [18:0]        x_init;
  logic [16:0]        z_init;
  logic signed [18:0] x_sh, y_sh, x_nxt, y_nxt, x_map, y_map;
  logic signed [16:0] z_nxt, atan_i;
  logic               unused_bits;

  assign launch = ui_in[7] & ~start_q;

  // x0 = r * 622 pre-divides by the CORDIC gain so x ends near r * 1024.
  assign x_init = 19'(ui_in[6:0]) * 19'd622;
  // One theta LSB is 1024 z units (65536 z units per turn); the top two
  // theta bits are handled by the quadrant fold, so z0 is at most 84.4 deg.
  assign z_init = {3'b000, uio_in[3:0], 10'd0};

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    step       = 1'b0;
    write_back = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          load      = 1'b1;
          state_nxt = ROTATE;
        end
      end
      ROTATE: begin
        if (iter == WRITE_BACK) begin
          write_back = 1'b1;
          state_nxt  = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (launch) begin
          load      = 1'b1;
          state_nxt = ROTATE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else if (ena) begin
      state   <= state_nxt;
      start_q <= ui_in[7];
    end
  end

  // atan(2^-i) in units of 65536 per turn
  always_comb begin
    case (iter)
      4'd0:    atan_i = 17'sd8192;
      4'd1:    atan_i = 17'sd4836;
      4'd2:    atan_i = 17'sd2555;
      4'd3:    atan_i = 17'sd1297;
      4'd4:    atan_i = 17'sd651;
      4'd5:    atan_i = 17'sd326;
      4'd6:    atan_i = 17'sd163;
      4'd7:    atan_i = 17'sd81;
      4'd8:    atan_i = 17'sd41;
      4'd9:    atan_i = 17'sd20;
      default: atan_i = 17'sd0;
    endcase
  end

  assign x_sh = x >>> iter;
  assign y_sh = y >>> iter;

  // z >= 0 rotates counter-clockwise (d = +1); negative z rotates back.
  assign x_nxt = z[16] ? (x + y_sh) : (x - y_sh);
  assign y_nxt = z[16] ? (y - x_sh) : (y + x_sh);
  assign z_nxt = z[16] ? (z + atan_i) : (z - atan_i);

  always_comb begin
    x_map = x;
    y_map = y;
    case (quad)
      2'd0: begin x_map = x;  y_map = y;  end
      2'd1: begin x_map = -y; y_map = x;  end
      2'd2: begin x_map = -x; y_map = -y; end
      2'd3: begin x_map = y;  y_map = -x; end
      default: begin x_map = x; y_map = y; end
    endcase
  end

  // Round to nearest integer (10 fractional bits) and clamp to +/-127 so
  // the result is symmetric and never reaches -128.
  function automatic logic [7:0] round_sat(input logic signed [18:0] v);
    logic signed [18:0] t;
    t = (v + 19'sd512) >>> 10;
    if (t > 19'sd127)
      round_sat = 8'h7F;
    else if (t < -19'sd127)
      round_sat = 8'h81;
    else
      round_sat = t[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      quad <= '0;
      iter <= '0;
      xr   <= '0;
      yr   <= '0;
      done <= 1'b0;
    end else if (ena) begin
      if (load) begin
        x    <= x_init;
        y    <= '0;
        z    <= z_init;
        quad <= uio_in[5:4];
        iter <= '0;
        done <= 1'b0;
      end else if (step) begin
        x    <= x_nxt;
        y    <= y_nxt;
        z    <= z_nxt;
        iter <= iter + 4'd1;
      end else if (write_back) begin
        xr   <= round_sat(x_map);
        yr   <= round_sat(y_map);
        done <= 1'b1;
        iter <= '0;
      end
    end
  end

  assign uo_out      = uio_in[6] ? yr : xr;
  assign uio_out     = {done, 7'd0};
  assign uio_oe      = 8'h80;
  assign unused_bits = uio_in[7];

endmodule
